// File: rtl/jar_sram_pkg.sv
// rtl/jar_sram_pkg.sv - shared widths, pin map and sequencer states for the nibble-serial SRAM
package jar_sram_pkg;

  // SRAM geometry shared with the SRAM block: one nibble per beat, byte-wide data
  localparam int SRAM_AW = 4;
  localparam int SRAM_DW = 2 * SRAM_AW;

  // Bit positions on the 8-pin SRAM bus
  localparam int PIN_CLK = 0;
  localparam int PIN_RST = 1;
  localparam int PIN_WE  = 2;
  localparam int PIN_OE  = 3;
  localparam int NIB_LSB = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_W_LO,
    ST_W_HI,
    ST_W_ADDR,
    ST_RD,
    ST_RD_SAMPLE
  } state_t;

endpackage

// File: rtl/jar_sram_phase_gen.sv
// rtl/jar_sram_phase_gen.sv - pin-clock half-period counter with phase bit and phase-end strobe
module jar_sram_phase_gen #(
  parameter int PHASE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic phase,
  output logic phase_end
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign phase_end = (cnt == LAST);

  // Count cycles within a half-period; flip phase at each half-period end, restart on start
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (phase_end) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jar_sram_master.sv
// rtl/jar_sram_master.sv - nibble-serial SRAM pin sequencer; optional pin reset via JAR_SRAM_MASTER_PIN_RESET_EN
module jar_sram_master
  import jar_sram_pkg::*;
#(
  parameter int AW           = SRAM_AW,
  parameter int DW           = SRAM_DW,
  parameter int PHASE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic [DW-1:0] sram_io_in,
  input  logic [DW-1:0] sram_io_out
);

`ifdef JAR_SRAM_MASTER_PIN_RESET_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          phase, phase_end;
  logic          accept, beat_done;
  logic          wr_done, rd_done;

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  // A beat is LOW then HIGH; it ends on the last cycle of the HIGH half
  assign beat_done = phase_end && phase;

  // Half-period timing; held cleared while idle so each request starts on a fresh LOW phase
  jar_sram_phase_gen #(
    .PHASE_CYCLES(PHASE_CYCLES)
  ) u_phase_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (state == ST_IDLE),
    .phase    (phase),
    .phase_end(phase_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  // Next-state and completion strobes
  always_comb begin
    state_nxt = state;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    case (state)
`ifdef JAR_SRAM_MASTER_PIN_RESET_EN
      ST_INIT:      if (beat_done) state_nxt = ST_IDLE;
`endif
      ST_IDLE:      if (accept) state_nxt = req_we ? ST_W_LO : ST_RD;
      ST_W_LO:      if (beat_done) state_nxt = ST_W_HI;
      ST_W_HI:      if (beat_done) state_nxt = ST_W_ADDR;
      ST_W_ADDR: begin
        if (beat_done) begin
          state_nxt = ST_IDLE;
          wr_done   = 1'b1;
        end
      end
      ST_RD:        if (beat_done) state_nxt = ST_RD_SAMPLE;
      ST_RD_SAMPLE: begin
        if (phase_end) begin
          state_nxt = ST_IDLE;
          rd_done   = 1'b1;
        end
      end
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and response register; rdata holds until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= wr_done || rd_done;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (wr_done) rsp_rdata <= '0;
      if (rd_done) rsp_rdata <= sram_io_out;
    end
  end

  // Pin bus from registered state only; pin data only moves with the LOW phase
  always_comb begin
    sram_io_in = '0;
    case (state)
`ifdef JAR_SRAM_MASTER_PIN_RESET_EN
      ST_INIT:   sram_io_in[PIN_RST] = !rst;
`endif
      ST_W_LO: begin
        sram_io_in[NIB_LSB +: AW] = wdata_q[AW-1:0];
        sram_io_in[PIN_WE]        = 1'b1;
        sram_io_in[PIN_CLK]       = phase;
      end
      ST_W_HI: begin
        sram_io_in[NIB_LSB +: AW] = wdata_q[DW-1:AW];
        sram_io_in[PIN_WE]        = 1'b1;
        sram_io_in[PIN_CLK]       = phase;
      end
      ST_W_ADDR: begin
        sram_io_in[NIB_LSB +: AW] = addr_q;
        sram_io_in[PIN_WE]        = 1'b1;
        sram_io_in[PIN_CLK]       = phase;
      end
      ST_RD: begin
        sram_io_in[NIB_LSB +: AW] = addr_q;
        sram_io_in[PIN_OE]        = 1'b1;
        sram_io_in[PIN_CLK]       = phase;
      end
      ST_RD_SAMPLE: begin
        sram_io_in[NIB_LSB +: AW] = addr_q;
        sram_io_in[PIN_OE]        = 1'b1;
      end
      default:   sram_io_in = '0;
    endcase
  end

endmodule

// File: tb/tb_jar_sram_master.sv
// tb/tb_jar_sram_master.sv - directed bench for jar_sram_master at P=1 and P=3 against a nibble SRAM model
module tb_jar_sram_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       resync = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = 4'h0;
  logic [7:0] req_wdata = 8'h00;

  logic       req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
  logic [7:0] rsp_rdata_a, rsp_rdata_b, io_in_a, io_in_b, io_out_a, io_out_b;
  logic       req_valid_a, req_valid_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] beats[$];

  always #5 clk = ~clk;

  assign req_valid_a = req_valid && !sel;
  assign req_valid_b = req_valid && sel;

  jar_sram_master #(.PHASE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .sram_io_in(io_in_a), .sram_io_out(io_out_a)
  );

  jar_sram_master #(.PHASE_CYCLES(3)) u_dut_p3 (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .sram_io_in(io_in_b), .sram_io_out(io_out_b)
  );

  wire       m_ready = sel ? req_ready_b : req_ready_a;
  wire       m_rsp   = sel ? rsp_valid_b : rsp_valid_a;
  wire [7:0] m_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
  wire [7:0] m_pins  = sel ? io_in_b : io_in_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Nibble-serial SRAM model, one per DUT: lo nibble, hi nibble, address per write
  logic [7:0] pins [2];
  logic [7:0] prev [2];
  logic [7:0] mem  [2][16];
  logic [1:0] ncnt [2];
  logic [3:0] lo [2], hi [2], raddr [2];

  assign pins[0]  = io_in_a;
  assign pins[1]  = io_in_b;
  assign io_out_a = (io_in_a[3] && !io_in_a[2]) ? mem[0][raddr[0]] : 8'h00;
  assign io_out_b = (io_in_b[3] && !io_in_b[2]) ? mem[1][raddr[1]] : 8'h00;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resync || pins[d][1]) begin
        ncnt[d] <= 2'd0;
      end else if (pins[d][0] && !prev[d][0]) begin
        if (pins[d][2] && !pins[d][3]) begin
          case (ncnt[d])
            2'd0:    lo[d] <= pins[d][7:4];
            2'd1:    hi[d] <= pins[d][7:4];
            default: mem[d][pins[d][7:4]] <= {hi[d], lo[d]};
          endcase
          ncnt[d] <= (ncnt[d] == 2'd2) ? 2'd0 : ncnt[d] + 2'd1;
        end else if (pins[d][3] && !pins[d][2]) begin
          raddr[d] <= pins[d][7:4];
        end
      end
      prev[d] <= pins[d];
    end
  end

  // Pin monitor: data stable across each clock rise, high half-period equals P, beat log
  logic [7:0] mon_prev [2];
  int         hi_run [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mon_prev[d] <= 8'h00;
        hi_run[d]   <= 0;
      end else begin
        if (pins[d][0] && !mon_prev[d][0]) begin
          check("pin_stable", {24'h0, pins[d][7:1]}, {24'h0, mon_prev[d][7:1]});
          if (d == int'(sel)) beats.push_back(pins[d]);
        end
        if (pins[d][0]) begin
          hi_run[d] <= hi_run[d] + 1;
        end else begin
          if (hi_run[d] != 0) check("half_period", hi_run[d], (d == 0) ? 1 : 3);
          hi_run[d] <= 0;
        end
        mon_prev[d] <= pins[d];
      end
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [3:0] a,
                        input logic [7:0] d, input int exp_lat, input logic [7:0] exp_rd);
    int w;
    int n;
    w = 0;
    while (!m_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_ready_wait"}, w < 50, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~a;
    req_wdata = ~d;
    check({tag, "_busy"}, m_ready, 0);
    n = 1;
    while (!m_rsp && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_rdata"}, m_rdata, exp_rd);
    check({tag, "_ready_at_rsp"}, m_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_init;
    int n_rsp;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pins_a", io_in_a, 8'h00);
    check("rst_pins_b", io_in_b, 8'h00);
    check("rst_rsp_valid", rsp_valid_a, 0);
    check("rst_rdata", rsp_rdata_a, 8'h00);
`ifdef JAR_SRAM_MASTER_PIN_RESET_EN
    check("rst_ready", req_ready_a, 0);
`else
    check("rst_ready", req_ready_a, 1);
`endif
    rst    = 1'b0;
    resync = 1'b0;

    // Single write: three beats 0x3, 0xA, 0x5 with we=1 oe=0
    beats.delete();
    do_req("wr_a3", 1'b1, 4'h5, 8'hA3, 7, 8'h00);
    @(posedge clk); #1;
    check("wr_pulse_one_cycle", m_rsp, 0);
    check("wr_beat_count", beats.size(), 3);
    if (beats.size() == 3) begin
      check("wr_beat_lo", beats[0], 8'h35);
      check("wr_beat_hi", beats[1], 8'hA5);
      check("wr_beat_addr", beats[2], 8'h55);
    end

    // Read back: one beat with oe=1 we=0 nibble=addr
    beats.delete();
    do_req("rd_a3", 1'b0, 4'h5, 8'h00, 4, 8'hA3);
    @(posedge clk); #1;
    check("rd_pulse_one_cycle", m_rsp, 0);
    check("rd_rdata_hold", m_rdata, 8'hA3);
    check("rd_beat_count", beats.size(), 1);
    if (beats.size() == 1) check("rd_beat", beats[0], 8'h59);

    // Back-to-back sweep of all addresses
    for (int i = 0; i < 16; i++) do_req("b2b_wr", 1'b1, 4'(i), 8'(i * 8'h11), 7, 8'h00);
    for (int i = 0; i < 16; i++) do_req("b2b_rd", 1'b0, 4'(i), 8'h00, 4, 8'(i * 8'h11));

    // Slow pin clock, P=3
    sel = 1'b1;
    @(posedge clk); #1;
    beats.delete();
    do_req("p3_wr", 1'b1, 4'hC, 8'h5A, 19, 8'h00);
    check("p3_wr_beats", beats.size(), 3);
    do_req("p3_rd", 1'b0, 4'hC, 8'h00, 10, 8'h5A);
    sel = 1'b0;
    @(posedge clk); #1;

    // Reset during W_HI: pins drop at once, no response
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'h5;
    req_wdata = 8'hB6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_whi_pins", io_in_a, 8'hB4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_pins", io_in_a, 8'h00);
    check("abort_rsp", rsp_valid_a, 0);
    rst = 1'b0;
    n_init = 0;
    n_rsp  = 0;
    for (int i = 0; i < 10; i++) begin
      if (io_in_a[1]) n_init++;
      if (rsp_valid_a) n_rsp++;
      @(posedge clk); #1;
    end
    check("abort_no_rsp", n_rsp, 0);
`ifdef JAR_SRAM_MASTER_PIN_RESET_EN
    check("init_pin_rst_cycles", n_init, 2);
`else
    check("init_pin_rst_cycles", n_init, 0);
    resync = 1'b1;
    @(posedge clk); #1;
    resync = 1'b0;
`endif
    check("abort_ready", req_ready_a, 1);
    do_req("post_wr", 1'b1, 4'h7, 8'h42, 7, 8'h00);
    do_req("post_rd", 1'b0, 4'h7, 8'h00, 4, 8'h42);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
